// File: rtl/reg_status_uart_if.sv
// Bundle of the status inputs, the enable and the UART/counter outputs
// shared between the status reporter and whatever drives or observes it.
interface reg_status_uart_if;
  logic [9:0]  reg_in;
  logic        report_en;
  logic        uart_tx;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  modport master (
    output reg_in, report_en,
    input  uart_tx, busy, frame_cnt, drop_cnt
  );

  modport slave (
    input  reg_in, report_en,
    output uart_tx, busy, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/reg_status_uart.sv
// Snapshots the ten register status bits and prints each new value as an
// ASCII line ("dddddddddd\r\n", reg10 first) on an 8N1 UART TX pin.
//
// state | meaning
// IDLE  | line high, waiting for report_en and a new (or forced) value
// START | start bit (0) of the current character
// DATA  | data bit bit_idx of the current character, LSB first
// STOP  | stop bit (1); after char 11 the frame ends
module reg_status_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_status_uart_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [3:0]    char_idx, char_idx_n;
  logic [9:0]    snap;
  logic [9:0]    last_sent;
  logic [9:0]    prev_in;
  logic          force_pending;
  logic          tx_q, tx_n;
  logic [15:0]   frame_cnt_q;
  logic [7:0]    drop_cnt_q;
  logic          trigger;
  logic          bit_done;
  logic          load;
  logic          frame_done;
  logic [7:0]    cur_char;

  // ASCII character idx of the line built from a snapshot
  function automatic logic [7:0] char_at(input logic [9:0] s, input logic [3:0] idx);
    logic [7:0] c;
    if (idx < 4'd10) c = s[4'd9 - idx] ? 8'h31 : 8'h30;
    else if (idx == 4'd10) c = 8'h0D;
    else c = 8'h0A;
    return c;
  endfunction

  assign trigger  = bus.report_en && (force_pending || (bus.reg_in != last_sent));
  assign bit_done = (bit_cnt == BIT_LAST);

  // next-state, counters and the registered TX level for the next cycle
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    char_idx_n = char_idx;
    load       = 1'b0;
    frame_done = 1'b0;
    tx_n       = 1'b1;
    cur_char   = 8'h00;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n    = START;
          bit_cnt_n  = '0;
          char_idx_n = 4'd0;
          load       = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          bit_idx_n = 3'd0;
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          if (char_idx == 4'd11) begin
            state_n    = IDLE;
            frame_done = 1'b1;
          end else begin
            char_idx_n = char_idx + 4'd1;
            state_n    = START;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // snap is already loaded whenever DATA is entered, so it is safe to use here
    cur_char = char_at(snap, char_idx_n);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_char[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  // FSM state, bit timing and TX output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      char_idx <= 4'd0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      char_idx <= char_idx_n;
      tx_q     <= tx_n;
    end
  end

  // snapshot and change-detection reference taken on the trigger edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap          <= 10'd0;
      last_sent     <= 10'd0;
      force_pending <= 1'b1;
    end else if (load) begin
      snap          <= bus.reg_in;
      last_sent     <= bus.reg_in;
      force_pending <= 1'b0;
    end
  end

  // completed-frame counter, wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= 16'd0;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  // count every enabled input change seen while a frame is in flight, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_in    <= 10'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      prev_in <= bus.reg_in;
      if ((state != IDLE) && bus.report_en && (bus.reg_in != prev_in) &&
          (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.uart_tx   = tx_q;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_reg_status_uart.sv
// Directed/randomised bench: every frame is captured bit-by-bit from the TX
// pin and compared with the waveform a 12-character 8N1 line must have.
module tb_reg_status_uart;

  localparam int CPB = 4;
  localparam int FRAME = 120 * CPB;

  logic clk;
  logic reset_n;
  reg_status_uart_if bus();

  reg_status_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int fc_exp = 0;
  int drop_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  // waits (bounded) for a start bit, then checks all 480 cycles of the frame
  task automatic capture(input logic [9:0] val, input int exp_wait, input string tag);
    logic [7:0] chars [12];
    logic [7:0] got [12];
    logic [7:0] ch;
    logic exp_bit;
    string exp_line, got_line;
    int w, bad_tx, bad_busy;
    for (int i = 0; i < 10; i++) chars[i] = val[9-i] ? 8'h31 : 8'h30;
    chars[10] = 8'h0D;
    chars[11] = 8'h0A;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.uart_tx !== 1'b0 && w < 2000);
    chk({tag, " start_bit"}, {31'd0, bus.uart_tx}, 32'd0);
    if (bus.uart_tx !== 1'b0) return;
    if (exp_wait > 0) chk({tag, " latency"}, w, exp_wait);
    bad_tx = 0;
    bad_busy = 0;
    for (int c = 0; c < 12; c++) begin
      ch = chars[c];
      got[c] = 8'h00;
      for (int b = 0; b < 10; b++) begin
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
        for (int k = 0; k < CPB; k++) begin
          if (c != 0 || b != 0 || k != 0) @(negedge clk);
          if (bus.uart_tx !== exp_bit) bad_tx++;
          if (bus.busy !== 1'b1) bad_busy++;
          if (k == CPB / 2 && b >= 1 && b <= 8) got[c][b-1] = bus.uart_tx;
        end
      end
    end
    exp_line = "";
    got_line = "";
    for (int i = 0; i < 10; i++) begin
      exp_line = $sformatf("%s%c", exp_line, chars[i]);
      got_line = $sformatf("%s%c", got_line, got[i]);
    end
    chk_s({tag, " line"}, got_line, exp_line);
    chk({tag, " cr"}, {24'd0, got[10]}, 32'h0D);
    chk({tag, " lf"}, {24'd0, got[11]}, 32'h0A);
    chk({tag, " bit_timing_errs"}, bad_tx, 0);
    chk({tag, " busy_low_cycles"}, bad_busy, 0);
    @(negedge clk);
    fc_exp++;
    chk({tag, " busy_end"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " frame_cnt"}, {16'd0, bus.frame_cnt}, fc_exp);
  endtask

  task automatic watch_idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk({tag, " idle_errs"}, bad, 0);
  endtask

  function automatic logic [9:0] pick_diff(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] v;
    do v = 10'($urandom_range(0, 1023)); while (v == a || v == b);
    return v;
  endfunction

  initial begin
    logic [9:0] v0, v1, v2, ra, rb, last;
    reset_n = 1'b0;
    bus.reg_in = 10'h3FF;
    bus.report_en = 1'b1;

    // reset values, then reset asserted in the middle of a frame
    repeat (3) @(negedge clk);
    chk("rst uart_tx", {31'd0, bus.uart_tx}, 32'd1);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
    chk("rst drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midframe busy", {31'd0, bus.busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async uart_tx", {31'd0, bus.uart_tx}, 32'd1);
    chk("async busy", {31'd0, bus.busy}, 32'd0);
    chk("async frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);

    // forced first frame of all zeros, and nothing after it
    bus.reg_in = 10'h000;
    @(negedge clk);
    reset_n = 1'b1;
    capture(10'h000, 1, "force0");
    watch_idle(100, "no_second");

    // reg10 and reg1 set
    bus.reg_in = 10'h201;
    capture(10'h201, 1, "r10r1");

    // intermediate values while busy: first the fixed case, then random ones
    for (int it = 0; it < 3; it++) begin
      last = bus.reg_in;
      if (it == 0) begin
        v0 = 10'h001; v1 = 10'h002; v2 = 10'h003;
      end else begin
        v0 = pick_diff(last, last);
        v1 = pick_diff(v0, v0);
        v2 = pick_diff(v1, v0);
      end
      bus.reg_in = v0;
      fork
        capture(v0, 1, $sformatf("drop%0d_a", it));
        begin
          repeat (100) @(negedge clk);
          bus.reg_in = v1;
          @(negedge clk);
          bus.reg_in = v2;
        end
      join
      drop_exp += 2;
      chk($sformatf("drop%0d drop_cnt", it), {24'd0, bus.drop_cnt}, drop_exp);
      capture(v2, 1, $sformatf("drop%0d_b", it));
    end

    // disabled: changes ignored, then one frame on re-enable
    bus.report_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.reg_in = 10'($urandom_range(0, 1023));
    end
    @(negedge clk);
    bus.reg_in = 10'h155;
    watch_idle(1000, "disabled");
    chk("disabled drop_cnt", {24'd0, bus.drop_cnt}, drop_exp);
    bus.report_en = 1'b1;
    capture(10'h155, 1, "reenable");

    // report_en dropped mid-frame: frame completes, later change is ignored
    v0 = pick_diff(10'h155, 10'h155);
    v1 = pick_diff(v0, 10'h155);
    bus.reg_in = v0;
    fork
      capture(v0, 1, "en_drop");
      begin
        repeat (50) @(negedge clk);
        bus.report_en = 1'b0;
        repeat (50) @(negedge clk);
        bus.reg_in = v1;
      end
    join
    watch_idle(100, "en_drop_after");
    chk("en_drop drop_cnt", {24'd0, bus.drop_cnt}, drop_exp);
    bus.reg_in = v0;
    bus.report_en = 1'b1;
    watch_idle(100, "same_value");

    // drop counter saturation with a back-to-back report of the final value
    v2 = pick_diff(v0, v0);
    ra = pick_diff(v2, v2);
    rb = pick_diff(v2, ra);
    bus.reg_in = v2;
    fork
      capture(v2, 1, "sat_a");
      begin
        repeat (20) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
          bus.reg_in = i[0] ? rb : ra;
          @(negedge clk);
        end
      end
    join
    chk("sat drop_cnt", {24'd0, bus.drop_cnt}, 32'hFF);
    capture(bus.reg_in, 1, "sat_b");
    watch_idle(50, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
